sdr_send: RTL and testbench
===========================

Name: sdr_send

Overview:
- Transmit-side counterpart of the port-1024 HPSDR command parser.
- Accepts the level requests raised by the parser: discovery reply, erase complete and send-more. Acknowledges each request and builds the fixed 60-byte Metis reply payload.
- Streams the payload byte-serially into the UDP transmit path under a request/grant handshake.
- Drives sending_sync back to the parser so the parser holds off while a reply is in flight.

Parameters:
- PAYLOAD_LEN, 60, UDP payload bytes per reply (minimum 11); bytes 11..PAYLOAD_LEN-1 are zero.
- TIMEOUT_CYCLES, 2_000_000, grant-wait limit in tx_clock cycles; used only with SDR_SEND_TIMEOUT_EN.

Ports:
- tx_clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- discovery_reply  in  1  level request from parser
- erase_done  in  1  level request: EPCS erase finished
- send_more  in  1  level request: ready for next 256-byte block
- running  in  1  radio streaming; selects discovery status byte
- local_mac  in  48  board MAC, sent MSB first
- code_version  in  8  firmware version byte
- board_type  in  8  board ID byte
- udp_tx_enable  in  1  one-cycle grant from UDP transmitter
- discovery_ACK  out  1  one-cycle pulse on capture of discovery_reply
- erase_ACK  out  1  one-cycle pulse on capture of erase_done
- send_more_ACK  out  1  one-cycle pulse on capture of send_more
- sending_sync  out  1  high from capture through last byte
- udp_tx_request  out  1  asking transmitter for a slot
- udp_tx_length  out  16  = PAYLOAD_LEN while udp_tx_request is high, else 0
- udp_tx_data  out  8  payload byte
- udp_tx_valid  out  1  udp_tx_data valid this cycle
- tx_timeout  out  1  one-cycle pulse on abandoned request (feature only)

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, kind register 0, all arm flags set.
- Arm flags: one per request input. A request is captured only while its flag is set. The flag clears on capture and sets again on any cycle the input is sampled low. This stops a request still high after its ACK from being captured twice.
- IDLE: evaluates armed, high requests in priority order: discovery_reply, then erase_done, then send_more. On capture:
  - pulse the matching ACK for one cycle;
  - latch kind;
  - sending_sync=1, udp_tx_request=1;
  - go to REQUEST.
  - Requests not served stay pending at their input and are evaluated in IDLE after DONE.
- REQUEST: hold request. On udp_tx_enable: request=0 the next cycle, counter=0, go to SEND.
- SEND: udp_tx_valid=1 for exactly PAYLOAD_LEN consecutive cycles. The first byte appears in the cycle after the grant. No back-pressure. Byte map by index:
  - 0: 0xEF
  - 1: 0xFE
  - 2: status
    - discovery: 0x02 if !running, 0x03 if running
    - erase_done: 0x03
    - send_more: 0x04
  - 3-8: local_mac[47:40] .. local_mac[7:0]
  - 9: code_version for discovery, else 0x00
  - 10: board_type for discovery, else 0x00
  - 11..PAYLOAD_LEN-1: 0x00
- local_mac, code_version, board_type and running are sampled at capture and held for the whole packet.
- After the last byte, go to DONE.
- DONE: one cycle. valid=0, sending_sync=0 at the end of this cycle. Then IDLE. Back-to-back replies therefore have at least one idle cycle between them.
- Grant while in IDLE, DONE or SEND: ignored.
- Reset mid-packet: output stops immediately, all state is cleared, no ACK is repeated. A request still high after reset is captured again, because the arm flags are set by reset.
- Byte counter width: clog2(PAYLOAD_LEN)+1 bits; no wrap inside a packet.

Optional Feature:
SDR_SEND_TIMEOUT_EN
- Defined: a counter runs in REQUEST.
  - If TIMEOUT_CYCLES elapse with no grant: drop udp_tx_request and sending_sync, pulse tx_timeout for one cycle, return to IDLE.
  - The request is not re-captured until its input has been low (arm-flag rule).
- Undefined: REQUEST waits indefinitely for a grant. tx_timeout is tied to 0.

Test Plan:
- Discovery: local_mac=00:1C:C0:A2:13:DD, running=0, code_version=0x21, board_type=0x01, discovery_reply held high until ACK, grant 5 cycles later -> discovery_ACK pulses once; 60 valid bytes EF FE 02 00 1C C0 A2 13 DD 21 01 followed by 49 zeros; sending_sync falls after the last byte.
- Discovery with running=1 -> byte 2 = 0x03, rest of the packet unchanged.
- Simultaneous: discovery_reply, erase_done and send_more all high in the same cycle, each dropped after its ACK, immediate grants -> three packets in order, status bytes 02, 03, 04; bytes 9-10 are 00 in the last two packets.
- Held request: send_more stuck high for 200 cycles -> exactly one send_more_ACK and one packet; a second packet only after send_more goes low and then high again.
- Reset asserted at byte 30 of a packet -> udp_tx_valid=0 and sending_sync=0 the next cycle; no further ACK pulses.
- With SDR_SEND_TIMEOUT_EN and TIMEOUT_CYCLES=100, no grant -> request drops after 100 cycles, tx_timeout pulses once, no data is sent; a later grant is ignored.

Source files
------------

// File: rtl/sdr_send.sv
// Purpose: builds the fixed Metis reply for the port-1024 parser and streams it byte-serially to the UDP transmitter.
// Latency: ACK and udp_tx_request 1 cycle after a request is sampled; first byte 1 cycle after the udp_tx_enable grant.
// Backpressure: none while streaming; waits in REQUEST for a grant, bounded by TIMEOUT_CYCLES when SDR_SEND_TIMEOUT_EN is defined.
module sdr_send #(
    parameter int PAYLOAD_LEN    = 60,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        tx_clock,
    input  logic        reset,
    input  logic        discovery_reply,
    input  logic        erase_done,
    input  logic        send_more,
    input  logic        running,
    input  logic [47:0] local_mac,
    input  logic [7:0]  code_version,
    input  logic [7:0]  board_type,
    input  logic        udp_tx_enable,
    output logic        discovery_ACK,
    output logic        erase_ACK,
    output logic        send_more_ACK,
    output logic        sending_sync,
    output logic        udp_tx_request,
    output logic [15:0] udp_tx_length,
    output logic [7:0]  udp_tx_data,
    output logic        udp_tx_valid,
    output logic        tx_timeout
);

    localparam int CW = $clog2(PAYLOAD_LEN) + 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_SEND, S_DONE} state_t;
    typedef enum logic [1:0] {K_DISCOVERY, K_ERASE, K_MORE} kind_t;

    // Everything the reply depends on, frozen at capture time.
    typedef struct packed {
        kind_t       kind;
        logic        running;
        logic [47:0] mac;
        logic [7:0]  version;
        logic [7:0]  board;
    } meta_t;

    state_t        state, state_nxt;
    logic [CW-1:0] byte_cnt;
    meta_t         meta_q;
    logic          arm_disc, arm_erase, arm_more;
    logic          cap_disc, cap_erase, cap_more, cap_any;
    logic          timeout_hit;

    // Priority capture of armed requests, only while idle.
    always_comb begin
        cap_disc  = 1'b0;
        cap_erase = 1'b0;
        cap_more  = 1'b0;
        if (state == S_IDLE) begin
            if (discovery_reply && arm_disc) begin
                cap_disc = 1'b1;
            end else if (erase_done && arm_erase) begin
                cap_erase = 1'b1;
            end else if (send_more && arm_more) begin
                cap_more = 1'b1;
            end
        end
    end

    assign cap_any = cap_disc | cap_erase | cap_more;

    // Next-state decode; a grant wins over a timeout landing on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (cap_any) state_nxt = S_REQUEST;
            S_REQUEST: begin
                if (udp_tx_enable) begin
                    state_nxt = S_SEND;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SEND:    if (byte_cnt == LAST_BYTE) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte index: cleared while waiting for a grant, stops at the last byte.
    always_ff @(posedge tx_clock) begin
        if (reset || state == S_REQUEST) begin
            byte_cnt <= '0;
        end else if (state == S_SEND && byte_cnt != LAST_BYTE) begin
            byte_cnt <= byte_cnt + CW'(1);
        end
    end

    // Arm flags: cleared by a capture, re-armed whenever the request is seen low.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            arm_disc  <= 1'b1;
            arm_erase <= 1'b1;
            arm_more  <= 1'b1;
        end else begin
            arm_disc  <= !discovery_reply || (arm_disc  && !cap_disc);
            arm_erase <= !erase_done      || (arm_erase && !cap_erase);
            arm_more  <= !send_more       || (arm_more  && !cap_more);
        end
    end

    // One-cycle acknowledge of whichever request was captured.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            discovery_ACK <= 1'b0;
            erase_ACK     <= 1'b0;
            send_more_ACK <= 1'b0;
        end else begin
            discovery_ACK <= cap_disc;
            erase_ACK     <= cap_erase;
            send_more_ACK <= cap_more;
        end
    end

    // Snapshot of reply kind and board identity at capture.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            meta_q <= '0;
        end else if (cap_any) begin
            meta_q.kind    <= cap_disc ? K_DISCOVERY : (cap_erase ? K_ERASE : K_MORE);
            meta_q.running <= running;
            meta_q.mac     <= local_mac;
            meta_q.version <= code_version;
            meta_q.board   <= board_type;
        end
    end

`ifdef SDR_SEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;

    // Counts cycles spent waiting for a grant; restarts on every new request.
    always_ff @(posedge tx_clock) begin
        if (reset || state != S_REQUEST) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    assign timeout_hit = (state == S_REQUEST) && (to_cnt == TO_LAST) && !udp_tx_enable;

    // Flags an abandoned request for one cycle.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            tx_timeout <= 1'b0;
        end else begin
            tx_timeout <= timeout_hit;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
    assign tx_timeout     = 1'b0;
`endif

    assign udp_tx_valid   = (state == S_SEND);
    assign udp_tx_request = (state == S_REQUEST);
    assign sending_sync   = (state == S_REQUEST) || (state == S_SEND);
    assign udp_tx_length  = udp_tx_request ? 16'(PAYLOAD_LEN) : 16'd0;

    // Payload byte map; everything past the board-type byte is zero padding.
    always_comb begin
        udp_tx_data = 8'h00;
        if (state == S_SEND) begin
            case (int'(byte_cnt))
                0:  udp_tx_data = 8'hEF;
                1:  udp_tx_data = 8'hFE;
                2: begin
                    case (meta_q.kind)
                        K_DISCOVERY: udp_tx_data = meta_q.running ? 8'h03 : 8'h02;
                        K_ERASE:     udp_tx_data = 8'h03;
                        default:     udp_tx_data = 8'h04;
                    endcase
                end
                3:  udp_tx_data = meta_q.mac[47:40];
                4:  udp_tx_data = meta_q.mac[39:32];
                5:  udp_tx_data = meta_q.mac[31:24];
                6:  udp_tx_data = meta_q.mac[23:16];
                7:  udp_tx_data = meta_q.mac[15:8];
                8:  udp_tx_data = meta_q.mac[7:0];
                9:  udp_tx_data = (meta_q.kind == K_DISCOVERY) ? meta_q.version : 8'h00;
                10: udp_tx_data = (meta_q.kind == K_DISCOVERY) ? meta_q.board : 8'h00;
                default: udp_tx_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_send.sv
module tb_sdr_send;

    localparam int PL = 60;
    localparam int TO = 100;

    logic        tx_clock = 1'b0;
    logic        reset;
    logic        discovery_reply, erase_done, send_more, running;
    logic [47:0] local_mac;
    logic [7:0]  code_version, board_type;
    logic        udp_tx_enable;
    logic        discovery_ACK, erase_ACK, send_more_ACK, sending_sync;
    logic        udp_tx_request, udp_tx_valid, tx_timeout;
    logic [15:0] udp_tx_length;
    logic [7:0]  udp_tx_data;

    sdr_send #(.PAYLOAD_LEN(PL), .TIMEOUT_CYCLES(TO)) dut (
        .tx_clock(tx_clock), .reset(reset),
        .discovery_reply(discovery_reply), .erase_done(erase_done), .send_more(send_more),
        .running(running), .local_mac(local_mac), .code_version(code_version), .board_type(board_type),
        .udp_tx_enable(udp_tx_enable),
        .discovery_ACK(discovery_ACK), .erase_ACK(erase_ACK), .send_more_ACK(send_more_ACK),
        .sending_sync(sending_sync), .udp_tx_request(udp_tx_request), .udp_tx_length(udp_tx_length),
        .udp_tx_data(udp_tx_data), .udp_tx_valid(udp_tx_valid), .tx_timeout(tx_timeout)
    );

    always #5 tx_clock = ~tx_clock;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt [3];
    int valid_cycles = 0;
    int timeout_cnt  = 0;

    // Event counters sampled on the falling edge.
    always @(negedge tx_clock) begin
        if (discovery_ACK) ack_cnt[0]++;
        if (erase_ACK)     ack_cnt[1]++;
        if (send_more_ACK) ack_cnt[2]++;
        if (udp_tx_valid)  valid_cycles++;
        if (tx_timeout)    timeout_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge tx_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic bit ack_now(input int k);
        case (k)
            0:       return discovery_ACK;
            1:       return erase_ACK;
            default: return send_more_ACK;
        endcase
    endfunction

    task automatic set_req(input int k, input logic v);
        case (k)
            0:       discovery_reply = v;
            1:       erase_done      = v;
            default: send_more       = v;
        endcase
    endtask

    // Reference reply: header, status, MAC, identity bytes, then zero padding.
    function automatic logic [7:0] model_byte(input int idx, input int kind, input bit run,
                                              input logic [47:0] mac, input logic [7:0] ver,
                                              input logic [7:0] brd);
        logic [7:0] hdr [11];
        hdr[0] = 8'hEF;
        hdr[1] = 8'hFE;
        if (kind == 0)      hdr[2] = run ? 8'h03 : 8'h02;
        else if (kind == 1) hdr[2] = 8'h03;
        else                hdr[2] = 8'h04;
        for (int i = 0; i < 6; i++) hdr[3 + i] = mac[47 - 8 * i -: 8];
        hdr[9]  = (kind == 0) ? ver : 8'h00;
        hdr[10] = (kind == 0) ? brd : 8'h00;
        return (idx < 11) ? hdr[idx] : 8'h00;
    endfunction

    task automatic scramble_fields();
        running      = 1'($urandom_range(0, 1));
        local_mac    = {16'($urandom), $urandom};
        code_version = 8'($urandom);
        board_type   = 8'($urandom);
    endtask

    // One complete reply: request, ACK, grant after gdelay, collect and compare.
    task automatic do_packet(input int kind, input bit run, input logic [47:0] mac,
                             input logic [7:0] ver, input logic [7:0] brd, input int gdelay,
                             input bit raise, input bit drop, input bit grant_in_send,
                             input logic [7:0] exp_status, input logic [7:0] exp_b9);
        logic [7:0] got [PL];
        int ack_before, n, bad, sync_low, req_high;
        bit seen;
        running = run; local_mac = mac; code_version = ver; board_type = brd;
        ack_before = ack_cnt[kind];
        if (raise) set_req(kind, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = ack_now(kind);
        end
        check("ack_seen", 64'(seen), 64'(1));
        if (!seen) return;
        if (drop) set_req(kind, 1'b0);
        scramble_fields();
        repeat (gdelay) step();
        check("req_len", 64'({udp_tx_request, udp_tx_length}), 64'({1'b1, 16'(PL)}));
        udp_tx_enable = 1'b1;
        step();
        udp_tx_enable = 1'b0;
        check("ack_once", 64'(ack_cnt[kind] - ack_before), 64'(1));
        n = 0; bad = 0; sync_low = 0; req_high = 0;
        for (int i = 0; i < PL + 10; i++) begin
            if (!udp_tx_valid) break;
            if (n < PL) got[n] = udp_tx_data;
            n++;
            if (!sending_sync) sync_low++;
            if (udp_tx_request) req_high++;
            udp_tx_enable = grant_in_send && ($urandom_range(0, 3) == 0);
            step();
        end
        udp_tx_enable = 1'b0;
        check("byte_count", 64'(n), 64'(PL));
        check("sync_after", 64'(sending_sync), 64'(0));
        check("sync_during", 64'(sync_low), 64'(0));
        check("req_during", 64'(req_high), 64'(0));
        for (int i = 0; i < PL; i++)
            if (i < n && got[i] !== model_byte(i, kind, run, mac, ver, brd)) bad++;
        check("payload", 64'(bad), 64'(0));
        check("status", 64'(got[2]), 64'(exp_status));
        check("byte9", 64'(got[9]), 64'(exp_b9));
    endtask

    typedef struct packed {
        int          kind;
        bit          run;
        logic [47:0] mac;
        logic [7:0]  ver;
        logic [7:0]  brd;
        int          gdelay;
        logic [7:0]  exp_status;
        logic [7:0]  exp_b9;
    } vec_t;

    vec_t tbl [5];
    bit   seen;
    int   vb, a0, before_more, n;

    initial begin
        reset = 1'b1;
        discovery_reply = 1'b0; erase_done = 1'b0; send_more = 1'b0;
        running = 1'b0; local_mac = '0; code_version = '0; board_type = '0;
        udp_tx_enable = 1'b0;
        repeat (3) step();
        check("reset_outputs", 64'({discovery_ACK, erase_ACK, send_more_ACK, sending_sync, udp_tx_request,
                                    udp_tx_length, udp_tx_data, udp_tx_valid, tx_timeout}), 64'(0));
        reset = 1'b0;
        step();
        check("idle_outputs", 64'({discovery_ACK, erase_ACK, send_more_ACK, sending_sync, udp_tx_request,
                                   udp_tx_length, udp_tx_data, udp_tx_valid, tx_timeout}), 64'(0));

        tbl[0] = '{0, 1'b0, 48'h001CC0A213DD, 8'h21, 8'h01, 5, 8'h02, 8'h21};
        tbl[1] = '{0, 1'b1, 48'h001CC0A213DD, 8'h21, 8'h01, 2, 8'h03, 8'h21};
        tbl[2] = '{1, 1'b0, 48'hA1B2C3D4E5F6, 8'h33, 8'h05, 0, 8'h03, 8'h00};
        tbl[3] = '{2, 1'b1, 48'hFFFFFFFFFFFF, 8'hFF, 8'hFF, 7, 8'h04, 8'h00};
        tbl[4] = '{0, 1'b1, 48'h000000000001, 8'hFF, 8'h0A, 1, 8'h03, 8'hFF};
        for (int i = 0; i < 5; i++)
            do_packet(tbl[i].kind, tbl[i].run, tbl[i].mac, tbl[i].ver, tbl[i].brd, tbl[i].gdelay,
                      1'b1, 1'b1, 1'b0, tbl[i].exp_status, tbl[i].exp_b9);

        // All three requests raised together: served in priority order.
        discovery_reply = 1'b1; erase_done = 1'b1; send_more = 1'b1;
        do_packet(0, 1'b0, 48'h001CC0A213DD, 8'h21, 8'h01, 0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h21);
        do_packet(1, 1'b0, 48'h001CC0A213DD, 8'h21, 8'h01, 0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
        do_packet(2, 1'b0, 48'h001CC0A213DD, 8'h21, 8'h01, 0, 1'b0, 1'b1, 1'b0, 8'h04, 8'h00);

        // send_more held high: exactly one reply until it toggles.
        before_more = ack_cnt[2];
        vb = valid_cycles;
        do_packet(2, 1'b0, 48'h0123456789AB, 8'h10, 8'h02, 3, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00);
        repeat (130) step();
        check("held_acks", 64'(ack_cnt[2] - before_more), 64'(1));
        check("held_bytes", 64'(valid_cycles - vb), 64'(PL));
        send_more = 1'b0;
        step();
        do_packet(2, 1'b0, 48'h0123456789AB, 8'h10, 8'h02, 0, 1'b1, 1'b1, 1'b0, 8'h04, 8'h00);

        // Randomized replies with stray grants in idle and during streaming.
        for (int t = 0; t < 20; t++) begin
            int k, gd;
            bit r;
            logic [47:0] m;
            logic [7:0] v, b;
            k = $urandom_range(0, 2); gd = $urandom_range(0, 7); r = 1'($urandom_range(0, 1));
            m = {16'($urandom), $urandom}; v = 8'($urandom); b = 8'($urandom);
            vb = valid_cycles;
            udp_tx_enable = 1'b1;
            step();
            udp_tx_enable = 1'b0;
            repeat (2) step();
            check("idle_grant", 64'(valid_cycles - vb), 64'(0));
            do_packet(k, r, m, v, b, gd, 1'b1, 1'b1, 1'b1,
                      model_byte(2, k, r, m, v, b), model_byte(9, k, r, m, v, b));
        end

        // Reset in the middle of a packet.
        running = 1'b0; local_mac = 48'h001CC0A213DD; code_version = 8'h21; board_type = 8'h01;
        discovery_reply = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = discovery_ACK;
        end
        check("rst_ack", 64'(seen), 64'(1));
        discovery_reply = 1'b0;
        udp_tx_enable = 1'b1;
        step();
        udp_tx_enable = 1'b0;
        repeat (30) step();
        check("rst_byte30", 64'({udp_tx_valid, udp_tx_data}), 64'({1'b1, 8'h00}));
        reset = 1'b1;
        step();
        check("rst_stop", 64'({udp_tx_valid, sending_sync, udp_tx_request}), 64'(0));
        reset = 1'b0;
        a0 = ack_cnt[0] + ack_cnt[1] + ack_cnt[2];
        vb = valid_cycles;
        repeat (20) step();
        check("rst_no_ack", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] - a0), 64'(0));
        check("rst_no_data", 64'(valid_cycles - vb), 64'(0));

`ifdef SDR_SEND_TIMEOUT_EN
        discovery_reply = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = discovery_ACK;
        end
        check("to_ack", 64'(seen), 64'(1));
        discovery_reply = 1'b0;
        n = 0;
        for (int i = 0; i < 3 * TO; i++) begin
            if (!udp_tx_request) break;
            n++;
            step();
        end
        check("to_req_cycles", 64'(n), 64'(TO));
        check("to_pulse", 64'({tx_timeout, sending_sync}), 64'({1'b1, 1'b0}));
        vb = valid_cycles;
        udp_tx_enable = 1'b1;
        step();
        udp_tx_enable = 1'b0;
        repeat (5) step();
        check("to_no_data", 64'(valid_cycles - vb), 64'(0));
        check("to_pulse_count", 64'(timeout_cnt), 64'(1));
`else
        check("no_timeout", 64'(timeout_cnt), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
